// File: rtl/warp_barrier_ctrl.sv
// -----------------------------------------------------------------------------
// warp_barrier_ctrl
//
// Barrier sequencer for the streaming multiprocessor. It sits beside the warp
// scheduler, records which participating warps have issued BAR, and releases
// them together once every live member has arrived. EXIT retirements shrink
// the membership, so an exit can be the event that completes a barrier.
//
// Optional feature (compile-time macro):
//   WARP_BARRIER_TIMEOUT_EN  - when defined, a deadlock counter runs while the
//                              barrier is partially filled and raises the
//                              sticky 'timeout' flag after TIMEOUT_CYCLES idle
//                              cycles. When undefined, 'timeout' is tied low.
//
// Parameters:
//   NUM_WARPS       resident warp slots
//   WID_W           warp-index width
//   TIMEOUT_CYCLES  deadlock threshold (timeout build only)
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   launch_valid    kernel launch; loads launch_mask as the membership
//   launch_mask     participating warps for the launch
//   arrive_valid    a warp issued BAR this cycle
//   arrive_warp     index of the arriving warp
//   exit_valid      a warp retired EXIT this cycle
//   exit_warp       index of the exiting warp
//   warp_blocked    level, one bit per warp parked at the barrier
//   release_valid   one-cycle release pulse
//   release_mask    warps released (zero whenever release_valid is low)
//   all_exited      level, a launch occurred and no members remain
//   barrier_count   completed barriers, wraps modulo 2^16
//   err_arrive      sticky, an arrival was ignored as illegal
//   timeout         sticky deadlock flag
// -----------------------------------------------------------------------------
module warp_barrier_ctrl #(
    parameter int NUM_WARPS      = 24,
    parameter int WID_W          = $clog2(NUM_WARPS),
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 launch_valid,
    input  logic [NUM_WARPS-1:0] launch_mask,
    input  logic                 arrive_valid,
    input  logic [WID_W-1:0]     arrive_warp,
    input  logic                 exit_valid,
    input  logic [WID_W-1:0]     exit_warp,
    output logic [NUM_WARPS-1:0] warp_blocked,
    output logic                 release_valid,
    output logic [NUM_WARPS-1:0] release_mask,
    output logic                 all_exited,
    output logic [15:0]          barrier_count,
    output logic                 err_arrive,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // no live members
        S_RUN  = 2'd1,  // members live, nobody waiting
        S_WAIT = 2'd2   // at least one member parked at the barrier
    } state_t;

    localparam logic [NUM_WARPS-1:0] ONE_HOT_0 = {{(NUM_WARPS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t               r_state;
    logic                 r_launched;
    logic [NUM_WARPS-1:0] r_member;
    logic [NUM_WARPS-1:0] r_arrived;
    logic                 r_release_valid;
    logic [NUM_WARPS-1:0] r_release_mask;
    logic [15:0]          r_barrier_count;
    logic                 r_err_arrive;

    // ------------------------------------------------------------------
    // Next-value computation
    // ------------------------------------------------------------------
    logic [NUM_WARPS-1:0] w_arr_oh;
    logic [NUM_WARPS-1:0] w_exit_oh;
    logic                 w_same_warp;
    logic                 w_arr_ok;
    logic                 w_arr_err;
    logic                 w_exit_eff;
    logic [NUM_WARPS-1:0] w_member_n;
    logic [NUM_WARPS-1:0] w_arrived_n;
    logic                 w_done;

    // NOTE: every always_comb output gets a default on entry so that no path
    // leaves it unassigned; that is what keeps this block free of latches.
    always_comb begin
        w_arr_oh    = '0;
        w_exit_oh   = '0;
        w_same_warp = 1'b0;
        w_arr_ok    = 1'b0;
        w_arr_err   = 1'b0;
        w_exit_eff  = 1'b0;
        w_member_n  = r_member;
        w_arrived_n = r_arrived;
        w_done      = 1'b0;

        // A left shift past the vector width yields zero, so indices at or
        // above NUM_WARPS decode to an empty mask and behave as non-members.
        if (arrive_valid) w_arr_oh  = ONE_HOT_0 << arrive_warp;
        if (exit_valid)   w_exit_oh = ONE_HOT_0 << exit_warp;

        // Same-warp arrive+exit: the exit wins and the arrival is silently
        // dropped, without raising an error.
        w_same_warp = arrive_valid && exit_valid && (arrive_warp == exit_warp);

        w_arr_ok   = !w_same_warp && (|(w_arr_oh & r_member & ~r_arrived));
        w_arr_err  = arrive_valid && !w_same_warp && !w_arr_ok;
        w_exit_eff = |(w_exit_oh & r_member);

        w_member_n  = r_member & ~w_exit_oh;
        w_arrived_n = (r_arrived | (w_arr_ok ? w_arr_oh : '0)) & ~w_exit_oh;

        // Arrived is always a subset of member, so equality means every live
        // member is waiting; this also catches completion by an exit.
        w_done = (w_arrived_n != '0) && (w_arrived_n == w_member_n);
    end

    // ------------------------------------------------------------------
    // Barrier FSM and registered outputs
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments only, so every
    // register sees the values from before this edge regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_launched      <= 1'b0;
            r_member        <= '0;
            r_arrived       <= '0;
            r_release_valid <= 1'b0;
            r_release_mask  <= '0;
            r_barrier_count <= '0;
            r_err_arrive    <= 1'b0;
        end else if (launch_valid) begin
            // Launch overrides any same-cycle arrive or exit.
            r_launched      <= 1'b1;
            r_member        <= launch_mask;
            r_arrived       <= '0;
            r_release_valid <= 1'b0;
            r_release_mask  <= '0;
            r_barrier_count <= '0;
            r_err_arrive    <= 1'b0;
            r_state         <= (launch_mask != '0) ? S_RUN : S_IDLE;
        end else begin
            r_member        <= w_member_n;
            r_release_valid <= w_done;
            r_release_mask  <= w_done ? w_arrived_n : '0;
            if (w_arr_err) begin
                r_err_arrive <= 1'b1;
            end

            if (w_done) begin
                r_arrived       <= '0;
                r_barrier_count <= r_barrier_count + 16'd1;
                r_state         <= S_RUN;
            end else begin
                r_arrived <= w_arrived_n;
                if (w_member_n == '0) begin
                    r_state <= S_IDLE;
                end else if (w_arrived_n != '0) begin
                    r_state <= S_WAIT;
                end else begin
                    r_state <= S_RUN;
                end
            end
        end
    end

    assign warp_blocked  = r_arrived;
    assign release_valid = r_release_valid;
    assign release_mask  = r_release_mask;
    assign barrier_count = r_barrier_count;
    assign err_arrive    = r_err_arrive;
    // IDLE means no members; before any launch the flag must stay low.
    assign all_exited    = r_launched && (r_state == S_IDLE);

    // ------------------------------------------------------------------
    // Optional deadlock detector
    // ------------------------------------------------------------------
`ifdef WARP_BARRIER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;
    logic             w_tmo_clear;

    // Any forward progress restarts the count.
    assign w_tmo_clear = launch_valid || w_arr_ok || w_exit_eff || w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (launch_valid) begin
                r_timeout <= 1'b0;
            end
            if (w_tmo_clear) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == S_WAIT) && (r_tmo_cnt != TMO_MAX)) begin
                // Counter saturates at the threshold; the flag is sticky.
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
                if (r_tmo_cnt == TMO_MAX - 1'b1) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign timeout = r_timeout;
`else
    // Progress bookkeeping only feeds the deadlock detector.
    logic w_unused;
    assign w_unused = w_exit_eff;
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_warp_barrier_ctrl.sv
// -----------------------------------------------------------------------------
// tb_warp_barrier_ctrl
//
// Self-checking bench for warp_barrier_ctrl: a table of directed vectors, a
// randomized phase compared against a per-warp reference model, and hand
// sequences for timing, counter wrap, async reset and the deadlock timeout.
// -----------------------------------------------------------------------------
module tb_warp_barrier_ctrl;

    localparam int NW    = 24;
    localparam int WW    = 5;
    localparam int TMO_C = 100;

    logic          clk;
    logic          rst_n;
    logic          launch_valid;
    logic [NW-1:0] launch_mask;
    logic          arrive_valid;
    logic [WW-1:0] arrive_warp;
    logic          exit_valid;
    logic [WW-1:0] exit_warp;
    logic [NW-1:0] warp_blocked;
    logic          release_valid;
    logic [NW-1:0] release_mask;
    logic          all_exited;
    logic [15:0]   barrier_count;
    logic          err_arrive;
    logic          timeout;

    warp_barrier_ctrl #(
        .NUM_WARPS      (NW),
        .WID_W          (WW),
        .TIMEOUT_CYCLES (TMO_C)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .launch_valid  (launch_valid),
        .launch_mask   (launch_mask),
        .arrive_valid  (arrive_valid),
        .arrive_warp   (arrive_warp),
        .exit_valid    (exit_valid),
        .exit_warp     (exit_warp),
        .warp_blocked  (warp_blocked),
        .release_valid (release_valid),
        .release_mask  (release_mask),
        .all_exited    (all_exited),
        .barrier_count (barrier_count),
        .err_arrive    (err_arrive),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit l, input logic [NW-1:0] m, input bit av, input int aw,
                         input bit ev, input int ew);
        launch_valid = l;
        launch_mask  = m;
        arrive_valid = av;
        arrive_warp  = WW'(aw);
        exit_valid   = ev;
        exit_warp    = WW'(ew);
    endtask

    task automatic idle_inputs();
        drive(1'b0, '0, 1'b0, 0, 1'b0, 0);
    endtask

    // ------------------------------------------------------------------
    // Reference model: per-warp flags, completion by counting heads.
    // ------------------------------------------------------------------
    bit            m_member  [NW];
    bit            m_arrived [NW];
    bit            m_launched;
    bit            m_err;
    int            m_count;
    bit            m_rv;
    logic [NW-1:0] m_rmask;
    bit            m_all;

    function automatic logic [NW-1:0] pack_arrived();
        logic [NW-1:0] v;
        for (int i = 0; i < NW; i++) v[i] = m_arrived[i];
        return v;
    endfunction

    task automatic model_step(input bit l, input logic [NW-1:0] mask, input bit av, input int aw,
                              input bit ev, input int ew);
        int n_mem;
        int n_arr;
        m_rv    = 1'b0;
        m_rmask = '0;
        if (l) begin
            m_launched = 1'b1;
            m_err      = 1'b0;
            m_count    = 0;
            for (int i = 0; i < NW; i++) begin
                m_member[i]  = mask[i];
                m_arrived[i] = 1'b0;
            end
        end else begin
            if (av && !(ev && aw == ew)) begin
                if (aw < NW && m_member[aw] && !m_arrived[aw]) m_arrived[aw] = 1'b1;
                else m_err = 1'b1;
            end
            if (ev && ew < NW) begin
                m_member[ew]  = 1'b0;
                m_arrived[ew] = 1'b0;
            end
            n_mem = 0;
            n_arr = 0;
            for (int i = 0; i < NW; i++) begin
                n_mem += int'(m_member[i]);
                n_arr += int'(m_arrived[i]);
            end
            if (n_arr > 0 && n_arr == n_mem) begin
                m_rv    = 1'b1;
                m_rmask = pack_arrived();
                for (int i = 0; i < NW; i++) m_arrived[i] = 1'b0;
                m_count = (m_count + 1) % 65536;
            end
        end
        n_mem = 0;
        for (int i = 0; i < NW; i++) n_mem += int'(m_member[i]);
        m_all = m_launched && (n_mem == 0);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit            l;
        logic [NW-1:0] mask;
        bit            av;
        int            aw;
        bit            ev;
        int            ew;
        logic [NW-1:0] blk;
        bit            rv;
        logic [NW-1:0] rmask;
        bit            all;
        bit            err;
        int            cnt;
    } vec_t;

    function automatic vec_t mk(input bit l, input logic [NW-1:0] mask, input bit av, input int aw,
                                input bit ev, input int ew, input logic [NW-1:0] blk, input bit rv,
                                input logic [NW-1:0] rmask, input bit all, input bit err,
                                input int cnt);
        vec_t v;
        v.l = l; v.mask = mask; v.av = av; v.aw = aw; v.ev = ev; v.ew = ew;
        v.blk = blk; v.rv = rv; v.rmask = rmask; v.all = all; v.err = err; v.cnt = cnt;
        return v;
    endfunction

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    initial begin
        int  pulses;
        bit  arrive_at;

        //                 l   mask    av aw  ev ew   blk   rv rmask all err cnt
        tbl[0]  = mk(1'b1, 24'h3, 1'b0, 0, 1'b0, 0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 0);
        tbl[1]  = mk(1'b0, 24'h0, 1'b1, 5, 1'b0, 0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b1, 0);
        tbl[2]  = mk(1'b0, 24'h0, 1'b1, 0, 1'b0, 0, 24'h1, 1'b0, 24'h0, 1'b0, 1'b1, 0);
        tbl[3]  = mk(1'b0, 24'h0, 1'b1, 0, 1'b0, 0, 24'h1, 1'b0, 24'h0, 1'b0, 1'b1, 0);
        tbl[4]  = mk(1'b0, 24'h0, 1'b1, 1, 1'b0, 0, 24'h0, 1'b1, 24'h3, 1'b0, 1'b1, 1);
        tbl[5]  = mk(1'b0, 24'h0, 1'b0, 0, 1'b0, 0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b1, 1);
        tbl[6]  = mk(1'b1, 24'h7, 1'b1, 0, 1'b0, 0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 0);
        tbl[7]  = mk(1'b0, 24'h0, 1'b1, 0, 1'b0, 0, 24'h1, 1'b0, 24'h0, 1'b0, 1'b0, 0);
        tbl[8]  = mk(1'b0, 24'h0, 1'b1, 2, 1'b0, 0, 24'h5, 1'b0, 24'h0, 1'b0, 1'b0, 0);
        tbl[9]  = mk(1'b0, 24'h0, 1'b0, 0, 1'b1, 1, 24'h0, 1'b1, 24'h5, 1'b0, 1'b0, 1);
        tbl[10] = mk(1'b0, 24'h0, 1'b0, 0, 1'b1, 0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 1);
        tbl[11] = mk(1'b0, 24'h0, 1'b0, 0, 1'b1, 2, 24'h0, 1'b0, 24'h0, 1'b1, 1'b0, 1);
        tbl[12] = mk(1'b0, 24'h0, 1'b1, 3, 1'b0, 0, 24'h0, 1'b0, 24'h0, 1'b1, 1'b1, 1);
        tbl[13] = mk(1'b1, 24'h3, 1'b0, 0, 1'b0, 0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 0);
        tbl[14] = mk(1'b0, 24'h0, 1'b1, 0, 1'b0, 0, 24'h1, 1'b0, 24'h0, 1'b0, 1'b0, 0);
        tbl[15] = mk(1'b0, 24'h0, 1'b1, 1, 1'b1, 1, 24'h0, 1'b1, 24'h1, 1'b0, 1'b0, 1);
        tbl[16] = mk(1'b0, 24'h0, 1'b1, 0, 1'b0, 0, 24'h0, 1'b1, 24'h1, 1'b0, 1'b0, 2);
        tbl[17] = mk(1'b0, 24'h0, 1'b1, 31, 1'b0, 0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b1, 2);

        // ---------------- reset values ----------------
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_blocked", 32'(warp_blocked), 32'h0);
        check("rst_release_valid", 32'(release_valid), 32'h0);
        check("rst_release_mask", 32'(release_mask), 32'h0);
        check("rst_all_exited", 32'(all_exited), 32'h0);
        check("rst_barrier_count", 32'(barrier_count), 32'h0);
        check("rst_err_arrive", 32'(err_arrive), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- directed table ----------------
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].l, tbl[i].mask, tbl[i].av, tbl[i].aw, tbl[i].ev, tbl[i].ew);
            tick();
            idle_inputs();
            check($sformatf("vec%0d_blocked", i), 32'(warp_blocked), 32'(tbl[i].blk));
            check($sformatf("vec%0d_release_valid", i), 32'(release_valid), 32'(tbl[i].rv));
            check($sformatf("vec%0d_release_mask", i), 32'(release_mask), 32'(tbl[i].rmask));
            check($sformatf("vec%0d_all_exited", i), 32'(all_exited), 32'(tbl[i].all));
            check($sformatf("vec%0d_err_arrive", i), 32'(err_arrive), 32'(tbl[i].err));
            check($sformatf("vec%0d_barrier_count", i), 32'(barrier_count), 32'(tbl[i].cnt));
        end

        // ---------------- two-warp barrier timing ----------------
        for (int c = 0; c < 18; c++) begin
            drive(c == 0, 24'h3, (c == 10) || (c == 15), (c == 15) ? 1 : 0, 1'b0, 0);
            tick();
            idle_inputs();
            if (c == 9) check("tw_blocked_before", 32'(warp_blocked), 32'h0);
            if (c >= 10 && c <= 14) check($sformatf("tw_blocked_c%0d", c + 1), 32'(warp_blocked), 32'h1);
            if (c == 14) check("tw_no_early_release", 32'(release_valid), 32'h0);
            if (c == 15) begin
                check("tw_release_valid", 32'(release_valid), 32'h1);
                check("tw_release_mask", 32'(release_mask), 32'h3);
                check("tw_blocked_at_release", 32'(warp_blocked), 32'h0);
                check("tw_barrier_count", 32'(barrier_count), 32'h1);
            end
            if (c == 16) check("tw_single_pulse", 32'(release_valid), 32'h0);
        end

        // ---------------- randomized vs model ----------------
        drive(1'b1, 24'h0F, 1'b0, 0, 1'b0, 0);
        model_step(1'b1, 24'h0F, 1'b0, 0, 1'b0, 0);
        tick();
        for (int k = 0; k < 600; k++) begin
            bit            l;
            logic [NW-1:0] mask;
            bit            av;
            int            aw;
            bit            ev;
            int            ew;
            l    = ($urandom_range(0, 99) < 3);
            mask = NW'($urandom_range(0, 255));
            av   = ($urandom_range(0, 99) < 60);
            aw   = ($urandom_range(0, 15) == 0) ? 30 : int'($urandom_range(0, 7));
            ev   = ($urandom_range(0, 99) < 10);
            ew   = int'($urandom_range(0, 7));
            drive(l, mask, av, aw, ev, ew);
            model_step(l, mask, av, aw, ev, ew);
            tick();
            idle_inputs();
            check("rnd_blocked", 32'(warp_blocked), 32'(pack_arrived()));
            check("rnd_release_valid", 32'(release_valid), 32'(m_rv));
            check("rnd_release_mask", 32'(release_mask), 32'(m_rmask));
            check("rnd_all_exited", 32'(all_exited), 32'(m_all));
            check("rnd_err_arrive", 32'(err_arrive), 32'(m_err));
            check("rnd_barrier_count", 32'(barrier_count), 32'(m_count));
        end

        // ---------------- back-to-back barriers and counter wrap ----------------
        drive(1'b1, 24'h1, 1'b0, 0, 1'b0, 0);
        tick();
        pulses = 0;
        for (int i = 0; i < 65537; i++) begin
            drive(1'b0, '0, 1'b1, 0, 1'b0, 0);
            tick();
            if (release_valid === 1'b1 && release_mask === 24'h1) pulses++;
        end
        idle_inputs();
        check("wrap_pulses", 32'(pulses), 32'd65537);
        check("wrap_barrier_count", 32'(barrier_count), 32'd1);
        check("wrap_err_arrive", 32'(err_arrive), 32'h0);

        // ---------------- async reset while a warp waits ----------------
        drive(1'b1, 24'h3, 1'b0, 0, 1'b0, 0);
        tick();
        drive(1'b0, '0, 1'b1, 0, 1'b0, 0);
        tick();
        idle_inputs();
        check("pre_rst_blocked", 32'(warp_blocked), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_blocked", 32'(warp_blocked), 32'h0);
        check("midrst_release_valid", 32'(release_valid), 32'h0);
        check("midrst_release_mask", 32'(release_mask), 32'h0);
        check("midrst_all_exited", 32'(all_exited), 32'h0);
        check("midrst_barrier_count", 32'(barrier_count), 32'h0);
        check("midrst_err_arrive", 32'(err_arrive), 32'h0);
        check("midrst_timeout", 32'(timeout), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_no_release", 32'(release_valid), 32'h0);

        // ---------------- deadlock timeout ----------------
        drive(1'b1, 24'h3, 1'b0, 0, 1'b0, 0);
        tick();
        drive(1'b0, '0, 1'b1, 0, 1'b0, 0);
        tick();
        idle_inputs();
        arrive_at = 1'b1;
        for (int i = 1; i < TMO_C; i++) tick();
        check("tmo_before_threshold", 32'(timeout), 32'h0);
        tick();
`ifdef WARP_BARRIER_TIMEOUT_EN
        check("tmo_at_threshold", 32'(timeout), 32'h1);
        for (int i = 0; i < 20; i++) tick();
        check("tmo_sticky", 32'(timeout), 32'h1);
        check("tmo_state_kept", 32'(warp_blocked), 32'h1);
        drive(1'b1, 24'h3, 1'b0, 0, 1'b0, 0);
        tick();
        idle_inputs();
        check("tmo_cleared_by_launch", 32'(timeout), 32'h0);
`else
        check("tmo_disabled", 32'(timeout), 32'h0);
        for (int i = 0; i < 50; i++) tick();
        check("tmo_disabled_late", 32'(timeout), 32'h0);
        check("tmo_state_kept", 32'(warp_blocked), 32'(arrive_at));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/warp_barrier_ctrl.md
# warp_barrier_ctrl

Barrier sequencer for the streaming multiprocessor: tracks which resident warps have issued `BAR` and releases them together once every live participating warp has arrived. It sits beside the warp scheduler. The scheduler reports `BAR` issue and `EXIT` retirement per warp; this block returns per-warp blocked levels and a one-cycle release pulse that the scheduler uses to return waiting warps to `W_READY`. It also flags protocol errors and, optionally, barrier deadlock.

## Interface
Parameters:
- `NUM_WARPS`, 24, resident warp slots.
- `WID_W`, `$clog2(NUM_WARPS)`, warp-index width.
- `TIMEOUT_CYCLES`, 1_000_000, deadlock threshold (used only with the macro below).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `launch_valid`  in  1  kernel launch; loads the membership mask.
- `launch_mask`  in  NUM_WARPS  participating warps.
- `arrive_valid`  in  1  a warp issued `BAR` this cycle.
- `arrive_warp`  in  WID_W  index of the arriving warp.
- `exit_valid`  in  1  a warp retired `EXIT` this cycle.
- `exit_warp`  in  WID_W  index of the exiting warp.
- `warp_blocked`  out  NUM_WARPS  level; warp is parked at the barrier.
- `release_valid`  out  1  one-cycle release pulse.
- `release_mask`  out  NUM_WARPS  warps released; valid only with `release_valid`.
- `all_exited`  out  1  level; a launch occurred and no members remain.
- `barrier_count`  out  16  number of completed barriers; wraps modulo 2^16.
- `err_arrive`  out  1  sticky; an arrival was ignored.
- `timeout`  out  1  sticky deadlock flag.

## Operation
- State registers:
  - `member[NUM_WARPS]`: live participants.
  - `arrived[NUM_WARPS]`: warps waiting at the barrier.
  - FSM with states `IDLE`, `RUN`, `WAIT`.
- `IDLE`: `member == 0`. Arrivals set `err_arrive`. Exits are ignored.
- `launch_valid`:
  - Sets `member = launch_mask`, clears `arrived`, `barrier_count`, `err_arrive` and `timeout`.
  - Next state is `RUN` if the mask is non-zero, else `IDLE`.
  - Launch overrides any arrive or exit in the same cycle.
- Arrival of warp w:
  - Accepted only if `member[w]=1`, `arrived[w]=0` and there is no same-cycle exit of w. An accepted arrival sets `arrived[w]`.
  - If the arrival is rejected for not being a member or for already being arrived, it is ignored and `err_arrive` is set.
  - If w also exits in the same cycle, the exit wins, the arrival is dropped, and no error is raised.
  - An `arrive_warp` index ≥ NUM_WARPS is treated as a non-member.
- Exit of warp w: clears `member[w]` and `arrived[w]`.
- Completion check, evaluated each cycle on next-state values `m'` (member) and `a'` (arrived):
  - If `a' != 0` and `a' == m'`:
    - Register `release_valid=1` and `release_mask=a'`.
    - Clear `arrived`.
    - Increment `barrier_count`.
    - Go to `RUN`.
  - An exit of the last non-arrived member therefore triggers a release.
- Other transitions:
  - `m' == 0` → `IDLE`, with `all_exited=1` (it is 0 before the first launch).
  - `a' != 0` without completion → `WAIT`.
- `warp_blocked = arrived`.
- An arrival in the cycle that `release_valid` is high counts toward the next barrier.

## Timing
- Reset values: every output is 0, `member=0`, `arrived=0`, state `IDLE`.
- Reset mid-barrier discards all waiting state. No release is issued.
- Arrive and exit inputs are sampled at a rising edge E. `warp_blocked` reflects the arrival in the cycle after E.
- Release latency: when the completing event is sampled at edge E, `release_valid` is high for exactly the cycle after E.
  - In that same cycle `warp_blocked` is already 0 and `barrier_count` is already incremented.
- At most one arrival and one exit per cycle. The scheduler guarantees this.
- `release_valid` never asserts on consecutive cycles unless a new full set of arrivals occurs. With one arrival per cycle, a single-member barrier can release every cycle.

## Configuration
- `WARP_BARRIER_TIMEOUT_EN` defined:
  - A counter runs while in `WAIT`.
  - It clears on any accepted arrival, exit, release or launch.
  - At `TIMEOUT_CYCLES` it sets sticky `timeout`. The state is otherwise unchanged.
- `WARP_BARRIER_TIMEOUT_EN` undefined: there is no counter and `timeout` is tied to 0.

## Test plan
- **Two-warp barrier.** Launch mask 0x3. Warp 0 arrives at cycle 10, warp 1 at cycle 15. Required: `warp_blocked`=0x1 for cycles 11-15; `release_valid` with mask 0x3 at cycle 16; `barrier_count`=1.
- **Exit completes barrier.** Launch 0x7. Warps 0 and 2 arrive, then warp 1 exits. Required: release mask 0x5 in the next cycle; after warps 0 and 2 exit, `all_exited`=1.
- **Protocol errors.** Launch 0x3. Warp 5 arrives, then warp 0 arrives twice. Required: `err_arrive`=1; a single release of 0x3 only after warp 1 arrives.
- **Simultaneous events.**
  - Arrive and exit of warp 1 in one cycle with launch 0x3 and warp 0 already arrived: release mask 0x1 and no error.
  - Launch together with an arrive: the arrival is ignored.
- **Back-to-back barriers, counter wrap, reset.** Mask 0x1 with an arrival every cycle for 65537 cycles: 65537 pulses and `barrier_count` ends at 1. Then assert `rst_n` low while warp 0 is waiting: all outputs go to 0.
- **Timeout** (macro on, `TIMEOUT_CYCLES`=100). Launch 0x3, warp 0 arrives, warp 1 is silent. Required: `timeout` rises 100 cycles after the arrival. With the macro off, `timeout` stays 0.
